// File: rtl/decode_queue.sv
// Purpose: RV32I decode stage; decodes each fetched word and queues it in a DEPTH-entry ring buffer.
// Latency: accept in cycle N -> head with out_valid in cycle N+1 when the queue was empty.
// Backpressure: in_ready = not full (registered, no bypass); out_valid = not empty; flush empties the queue.
// Ports: clk/rst_n (async active-low); flush; in_valid/in_ready/in_inst/in_pc from fetch;
//        out_valid/out_ready plus out_pc/out_op/out_rd/out_rs1/out_rs2/out_imm and the
//        decode flags toward dispatch; count = number of occupied entries.
module decode_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [ADDR_W-1:0]        in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [4:0]               out_op,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [31:0]              out_imm,
  output logic                     out_use_imm,
  output logic                     out_branch,
  output logic                     out_ls,
  output logic                     out_jalr,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Shared operation codes, ADD..LUI.
  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLL   = 5'd2,  OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4,  OP_XOR  = 5'd5,  OP_SRL   = 5'd6,  OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8,  OP_AND  = 5'd9,  OP_LB    = 5'd10, OP_LH   = 5'd11;
  localparam logic [4:0] OP_LW   = 5'd12, OP_LBU  = 5'd13, OP_LHU   = 5'd14, OP_SB   = 5'd15;
  localparam logic [4:0] OP_SH   = 5'd16, OP_SW   = 5'd17, OP_BEQ   = 5'd18, OP_BNE  = 5'd19;
  localparam logic [4:0] OP_BLT  = 5'd20, OP_BGE  = 5'd21, OP_BLTU  = 5'd22, OP_BGEU = 5'd23;
  localparam logic [4:0] OP_JAL  = 5'd24, OP_JALR = 5'd25, OP_AUIPC = 5'd26, OP_LUI  = 5'd27;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [4:0]        op;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              use_imm;
    logic              branch;
    logic              ls;
    logic              jalr;
    logic              illegal;
  } entry_t;

  // inst[30] picks SUB (register form only) and SRA/SRAI; other funct7 bits are ignored.
  function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic alt, input logic reg_reg);
    logic [4:0] op;
    case (f3)
      3'd0:    op = (reg_reg && alt) ? OP_SUB : OP_ADD;
      3'd1:    op = OP_SLL;
      3'd2:    op = OP_SLT;
      3'd3:    op = OP_SLTU;
      3'd4:    op = OP_XOR;
      3'd5:    op = alt ? OP_SRA : OP_SRL;
      3'd6:    op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;
  logic        bad;
  entry_t      dec;

  assign opc    = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'h000};
  assign imm_sh = {27'd0, in_inst[24:20]};

  always_comb begin
    bad         = 1'b0;
    dec         = '0;
    dec.pc      = in_pc;
    dec.rd      = in_inst[11:7];
    dec.rs1     = in_inst[19:15];
    dec.rs2     = in_inst[24:20];
    dec.op      = OP_ADD;
    dec.use_imm = 1'b1;
    case (opc)
      OPC_LUI:   begin dec.op = OP_LUI;   dec.imm = imm_u; end
      OPC_AUIPC: begin dec.op = OP_AUIPC; dec.imm = imm_u; end
      OPC_JAL:   begin dec.op = OP_JAL;   dec.imm = imm_j; dec.branch = 1'b1; end
      OPC_JALR: begin
        dec.op     = OP_JALR;
        dec.imm    = imm_i;
        dec.branch = 1'b1;
        dec.jalr   = 1'b1;
        bad        = (f3 != 3'd0);
      end
      OPC_BRANCH: begin
        dec.imm    = imm_b;
        dec.branch = 1'b1;
        case (f3)
          3'd0:    dec.op = OP_BEQ;
          3'd1:    dec.op = OP_BNE;
          3'd4:    dec.op = OP_BLT;
          3'd5:    dec.op = OP_BGE;
          3'd6:    dec.op = OP_BLTU;
          3'd7:    dec.op = OP_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.imm = imm_i;
        dec.ls  = 1'b1;
        case (f3)
          3'd0:    dec.op = OP_LB;
          3'd1:    dec.op = OP_LH;
          3'd2:    dec.op = OP_LW;
          3'd4:    dec.op = OP_LBU;
          3'd5:    dec.op = OP_LHU;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.imm = imm_s;
        dec.ls  = 1'b1;
        case (f3)
          3'd0:    dec.op = OP_SB;
          3'd1:    dec.op = OP_SH;
          3'd2:    dec.op = OP_SW;
          default: bad = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec.op  = alu_op(f3, in_inst[30], 1'b0);
        dec.imm = (f3 == 3'd1 || f3 == 3'd5) ? imm_sh : imm_i;
      end
      OPC_OP: begin
        dec.op      = alu_op(f3, in_inst[30], 1'b1);
        dec.use_imm = 1'b0;
      end
      default: bad = 1'b1;
    endcase
    // Illegal words still queue so dispatch can trap in order; scrub them to a harmless ADD.
    if (bad) begin
      dec.op      = OP_ADD;
      dec.imm     = '0;
      dec.use_imm = 1'b0;
      dec.branch  = 1'b0;
      dec.ls      = 1'b0;
      dec.jalr    = 1'b0;
    end
    dec.illegal = bad;
  end

  entry_t     mem [DEPTH];
  entry_t     head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic       enq, deq;

  // Ready/valid come from count only, so neither depends combinationally on the other side.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign enq       = in_valid && in_ready && !flush;
  assign deq       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= dec;
  end

  assign head        = mem[rd_ptr];
  assign out_pc      = head.pc;
  assign out_op      = head.op;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_imm     = head.imm;
  assign out_use_imm = head.use_imm;
  assign out_branch  = head.branch;
  assign out_ls      = head.ls;
  assign out_jalr    = head.jalr;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

  localparam int DEPTH = 4;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd2, SLT = 5'd3, SLTU = 5'd4;
  localparam logic [4:0] XOR = 5'd5, SRL = 5'd6, SRA = 5'd7, OR_ = 5'd8, AND_ = 5'd9;
  localparam logic [4:0] LB = 5'd10, LH = 5'd11, LW = 5'd12, LBU = 5'd13, LHU = 5'd14;
  localparam logic [4:0] SB = 5'd15, SH = 5'd16, SW = 5'd17;
  localparam logic [4:0] BEQ = 5'd18, BNE = 5'd19, BLT = 5'd20, BGE = 5'd21, BLTU = 5'd22, BGEU = 5'd23;
  localparam logic [4:0] JAL = 5'd24, JALR = 5'd25, AUIPC = 5'd26, LUI = 5'd27;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, out_imm;
  logic [4:0]  out_op, out_rd, out_rs1, out_rs2;
  logic        out_use_imm, out_branch, out_ls, out_jalr, out_illegal;
  logic [2:0]  count;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_use_imm(out_use_imm), .out_branch(out_branch), .out_ls(out_ls),
    .out_jalr(out_jalr), .out_illegal(out_illegal), .count(count)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  op, rd, rs1, rs2;
    logic [31:0] imm;
    logic        use_imm, branch, ls, jalr, illegal;
  } exp_t;

  exp_t mq[$];

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    return v[bits-1] ? v - (32'd1 << bits) : v;
  endfunction

  // Reference decode straight from the instruction-set rules.
  function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    logic [2:0] f3;
    f3 = w[14:12];
    e = '0;
    e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    e.op = ADD; e.use_imm = 1'b1;
    case (w[6:0])
      7'h37: begin e.op = LUI;   e.imm = {w[31:12], 12'h000}; end
      7'h17: begin e.op = AUIPC; e.imm = {w[31:12], 12'h000}; end
      7'h6F: begin e.op = JAL; e.branch = 1'b1;
        e.imm = sext({11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21); end
      7'h67: begin e.op = JALR; e.branch = 1'b1; e.jalr = 1'b1;
        e.imm = sext({20'd0, w[31:20]}, 12); e.illegal = (f3 != 0); end
      7'h63: begin e.branch = 1'b1;
        e.imm = sext({19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
        if (f3 == 2 || f3 == 3) e.illegal = 1'b1;
        else if (f3 == 0) e.op = BEQ; else if (f3 == 1) e.op = BNE;
        else if (f3 == 4) e.op = BLT; else if (f3 == 5) e.op = BGE;
        else if (f3 == 6) e.op = BLTU; else e.op = BGEU;
      end
      7'h03: begin e.ls = 1'b1; e.imm = sext({20'd0, w[31:20]}, 12);
        if (f3 == 0) e.op = LB; else if (f3 == 1) e.op = LH; else if (f3 == 2) e.op = LW;
        else if (f3 == 4) e.op = LBU; else if (f3 == 5) e.op = LHU; else e.illegal = 1'b1;
      end
      7'h23: begin e.ls = 1'b1; e.imm = sext({20'd0, w[31:25], w[11:7]}, 12);
        if (f3 == 0) e.op = SB; else if (f3 == 1) e.op = SH; else if (f3 == 2) e.op = SW;
        else e.illegal = 1'b1;
      end
      7'h13, 7'h33: begin
        if (f3 == 0) e.op = (w[5] && w[30]) ? SUB : ADD;
        else if (f3 == 1) e.op = SLL; else if (f3 == 2) e.op = SLT;
        else if (f3 == 3) e.op = SLTU; else if (f3 == 4) e.op = XOR;
        else if (f3 == 5) e.op = w[30] ? SRA : SRL;
        else if (f3 == 6) e.op = OR_; else e.op = AND_;
        if (w[5]) e.use_imm = 1'b0;
        else if (f3 == 1 || f3 == 5) e.imm = {27'd0, w[24:20]};
        else e.imm = sext({20'd0, w[31:20]}, 12);
      end
      default: e.illegal = 1'b1;
    endcase
    if (e.illegal) begin
      e.op = ADD; e.use_imm = 1'b0; e.branch = 1'b0; e.ls = 1'b0; e.jalr = 1'b0; e.imm = '0;
    end
    return e;
  endfunction

  // Advance the reference queue with the current inputs, then cross one clock edge.
  task automatic tick();
    bit enq, deq;
    enq = in_valid && (mq.size() != DEPTH) && !flush;
    deq = (mq.size() != 0) && out_ready && !flush;
    if (flush) mq.delete();
    else begin
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back(model_decode(in_inst, in_pc));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_pc = '0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mq.delete();
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  op, rd, rs1;
    logic [31:0] imm;
    logic        chk_imm;
    logic [4:0]  flags;   // {use_imm, branch, ls, jalr, illegal}
  } row_t;

  task automatic test_decode();
    row_t rows[14];
    rows[0]  = '{32'h00500093, ADD,   5'd1,  5'd0, 32'd5,        1'b1, 5'b10000};
    rows[1]  = '{32'h402081B3, SUB,   5'd3,  5'd1, 32'd0,        1'b0, 5'b00000};
    rows[2]  = '{32'h123452B7, LUI,   5'd5,  5'd8, 32'h12345000, 1'b1, 5'b10000};
    rows[3]  = '{32'h00008067, JALR,  5'd0,  5'd1, 32'd0,        1'b1, 5'b11010};
    rows[4]  = '{32'hFE000EE3, BEQ,   5'd29, 5'd0, 32'hFFFFFFFC, 1'b1, 5'b11000};
    rows[5]  = '{32'h41F0D093, SRA,   5'd1,  5'd1, 32'd31,       1'b1, 5'b10000};
    rows[6]  = '{32'h00000000, ADD,   5'd0,  5'd0, 32'd0,        1'b0, 5'b00001};
    rows[7]  = '{32'h0000307F, ADD,   5'd0,  5'd0, 32'd0,        1'b0, 5'b00001};
    rows[8]  = '{32'h0020A423, SW,    5'd8,  5'd1, 32'd8,        1'b1, 5'b10100};
    rows[9]  = '{32'h0000B083, ADD,   5'd1,  5'd1, 32'd0,        1'b0, 5'b00001};
    rows[10] = '{32'h0000A063, ADD,   5'd0,  5'd1, 32'd0,        1'b0, 5'b00001};
    rows[11] = '{32'h008000EF, JAL,   5'd1,  5'd0, 32'd8,        1'b1, 5'b11000};
    rows[12] = '{32'h00001117, AUIPC, 5'd2,  5'd0, 32'h00001000, 1'b1, 5'b10000};
    rows[13] = '{32'hFFC12283, LW,    5'd5,  5'd2, 32'hFFFFFFFC, 1'b1, 5'b10100};
    for (int i = 0; i < 14; i++) begin
      logic [31:0] pc;
      logic [4:0]  fl;
      pc = 32'h1000 + 32'(i * 4);
      in_valid = 1'b1; in_inst = rows[i].inst; in_pc = pc; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      fl = {out_use_imm, out_branch, out_ls, out_jalr, out_illegal};
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dec%0d_valid: got %b want 1", i, out_valid); end
      n_cmp++; if (out_op !== rows[i].op) begin n_err++; $display("FAIL dec%0d_op: got %0d want %0d", i, out_op, rows[i].op); end
      n_cmp++; if (out_rd !== rows[i].rd) begin n_err++; $display("FAIL dec%0d_rd: got %0d want %0d", i, out_rd, rows[i].rd); end
      n_cmp++; if (out_rs1 !== rows[i].rs1) begin n_err++; $display("FAIL dec%0d_rs1: got %0d want %0d", i, out_rs1, rows[i].rs1); end
      n_cmp++; if (fl !== rows[i].flags) begin n_err++; $display("FAIL dec%0d_flags: got %b want %b", i, fl, rows[i].flags); end
      n_cmp++; if (out_pc !== pc) begin n_err++; $display("FAIL dec%0d_pc: got %h want %h", i, out_pc, pc); end
      if (rows[i].chk_imm) begin
        n_cmp++; if (out_imm !== rows[i].imm) begin n_err++; $display("FAIL dec%0d_imm: got %h want %h", i, out_imm, rows[i].imm); end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL dec_drained: got %0d want 0", count); end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_inst = 32'h00000013 | (32'(i) << 20); in_pc = 32'h2000 + 32'(i * 4);
      if (i < 4) tick();
    end
    tick(); tick();
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_nobypass: got %b want 0", in_ready); end
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count_popcyc: got %0d want 4", count); end
    tick();
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL full_after_pop: got %0d want 3", count); end
    n_cmp++; if (out_pc !== 32'h2004) begin n_err++; $display("FAIL full_head1: got %h want 00002004", out_pc); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL full_fifth_in: got %0d want 3", count); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (out_pc !== 32'h2008 + 32'(4 * k)) begin
        n_err++; $display("FAIL full_order%0d: got %h want %h", k, out_pc, 32'h2008 + 32'(4 * k));
      end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_empty: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int popped;
    popped = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h3000 + 32'(i * 4);
      if (i == 3) out_ready = 1'b1;
      if (out_ready) begin
        n_cmp++;
        if (out_pc !== 32'h3000 + 32'(4 * popped)) begin
          n_err++; $display("FAIL wrap_order%0d: got %h want %h", popped, out_pc, 32'h3000 + 32'(4 * popped));
        end
        popped++;
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL wrap_count: got %0d want 3", count); end
    while (popped < 10) begin
      n_cmp++;
      if (out_pc !== 32'h3000 + 32'(4 * popped)) begin
        n_err++; $display("FAIL wrap_order%0d: got %h want %h", popped, out_pc, 32'h3000 + 32'(4 * popped));
      end
      popped++;
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_inst = 32'h00208033; in_pc = 32'h4000 + 32'(i * 4); tick();
    end
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre: got %0d want 3", count); end
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h4100;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    tick();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_noenq: got %0d want 0", count); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h5000 + 32'(i * 4); tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    mq.delete();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", out_valid); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_pc = 32'h5100; tick(); in_valid = 1'b0;
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL arst_resume: got %0d want 1", count); end
    n_cmp++; if (out_pc !== 32'h5100) begin n_err++; $display("FAIL arst_resume_pc: got %h want 00005100", out_pc); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0] opcs[9];
    bit pend;
    opcs = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17};
    pend = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bit acc;
      if (!pend && $urandom_range(0, 9) < 6) begin
        pend = 1'b1;
        in_inst = $urandom;
        if ($urandom_range(0, 4) != 0) in_inst[6:0] = opcs[$urandom_range(0, 8)];
        in_pc = $urandom & 32'hFFFF_FFFC;
      end
      in_valid  = pend;
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 39) == 0);
      n_cmp++;
      if (count !== 3'(mq.size())) begin n_err++; $display("FAIL rnd%0d_count: got %0d want %0d", c, count, mq.size()); end
      n_cmp++;
      if (in_ready !== (mq.size() != DEPTH)) begin n_err++; $display("FAIL rnd%0d_in_ready: got %b", c, in_ready); end
      n_cmp++;
      if (out_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd%0d_out_valid: got %b", c, out_valid); end
      if (mq.size() != 0) begin
        exp_t e;
        logic [56:0] act, want;
        e = mq[0];
        act  = {out_pc, out_op, out_rd, out_rs1, out_rs2, out_use_imm, out_branch, out_ls, out_jalr, out_illegal};
        want = {e.pc, e.op, e.rd, e.rs1, e.rs2, e.use_imm, e.branch, e.ls, e.jalr, e.illegal};
        n_cmp++;
        if (act !== want) begin n_err++; $display("FAIL rnd%0d_head: got %h want %h", c, act, want); end
        if (e.use_imm) begin
          n_cmp++;
          if (out_imm !== e.imm) begin n_err++; $display("FAIL rnd%0d_imm: got %h want %h", c, out_imm, e.imm); end
        end
      end
      acc = pend && (mq.size() != DEPTH) && !flush;
      tick();
      if (acc) pend = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_full();
    test_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised decode stage placed between instruction fetch and dispatch. Each fetched RV32I instruction word and its PC are accepted over a valid/ready handshake, decoded in the accept cycle, and the decoded fields are written into a circular buffer of DEPTH entries. Dispatch drains the buffer in order over a second valid/ready handshake. A flush input discards all queued entries on a branch mispredict. Unlike the plain combinational decoder, this stage adds buffering, backpressure, flush and illegal-instruction flagging.

## Interface
- DEPTH, 4: queue entries; a power of two, 2..32.
- ADDR_W, 32: PC width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- flush  in  1  synchronous clear of all queued entries.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept; equals (count != DEPTH).
- in_inst  in  32  instruction word.
- in_pc  in  ADDR_W  instruction address.
- out_valid  out  1  head entry is valid; equals (count != 0).
- out_ready  in  1  dispatch consumes the head.
- out_pc  out  ADDR_W  head PC.
- out_op  out  5  operation code from the shared op definitions (ADD..LUI).
- out_rd, out_rs1, out_rs2  out  5 each  register fields, inst[11:7], [19:15], [24:20].
- out_imm  out  32  decoded immediate.
- out_use_imm, out_branch, out_ls, out_jalr, out_illegal  out  1 each  decode flags.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Decode happens combinationally on in_inst, with the entry stored registered.
- LUI and AUIPC: imm = {inst[31:12], 12'b0}.
- I-type (OP-IMM, LOAD, JALR): imm is sign-extended inst[31:20].
- Shift immediates: imm = {27'b0, inst[24:20]}.
- S-type: imm = sext{inst[31:25], inst[11:7]}.
- B-type: imm = sext{inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- J-type: imm = sext{inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- SUB and SRA/SRAI are selected by inst[30]. Every other funct7 bit is ignored.
- Flags:
  - branch = BR, JAL or JALR.
  - ls = LOAD or STORE.
  - use_imm = 0 only for OP (register-register).
  - jalr = (op == JALR).
- Fields rs1, rs2 and rd are always copied from the instruction, whatever the format.
- illegal = 1 for any of the following:
  - an opcode outside the nine RV32I classes;
  - LOAD funct3 of 3, 6 or 7;
  - STORE funct3 of 3 or greater;
  - BRANCH funct3 of 2 or 3;
  - JALR funct3 not equal to 0.
- An illegal entry still queues, with op = ADD, use_imm = 0 and all other flags 0.
- Storage:
  - wr_ptr, rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is tracked separately so that full and empty can be told apart.
- Enqueue when in_valid && in_ready && !flush. Dequeue when out_valid && out_ready && !flush.
- Simultaneous enqueue and dequeue: both pointers advance and count is unchanged.
- Full: in_ready = 0 even if a dequeue occurs in the same cycle. There is no bypass.
- Empty: out_valid = 0. out_* fields hold the stale head slot, and dispatch must ignore them.
- Flush: wr_ptr, rd_ptr and count all go to 0 at the edge. Any enqueue and dequeue in that cycle are dropped. Fetch must re-present the dropped instruction.

## Timing
- Reset (rst_n low, asynchronous):
  - wr_ptr = rd_ptr = count = 0, so in_ready = 1 and out_valid = 0.
  - Storage is not reset. out_* outputs read slot 0 contents and are don't-care while out_valid = 0.
- Latency: an instruction accepted in cycle N appears at the head with out_valid = 1 in cycle N+1, if the queue was empty.
- Handshakes: in_ready, out_valid and count are functions of registered state only. There is no combinational path from in_valid or out_ready.
- Producers hold in_inst/in_pc stable while in_valid && !in_ready. Head outputs are stable until dequeue.
- Reset asserted mid-operation empties the queue immediately. Operation resumes on the first edge after deassertion.

## Test plan
- Reset, then enqueue 0x00500093 (addi x1,x0,5) at PC 0x1000.
  - Required: next cycle out_valid = 1, op = ADD, rd = 1, rs1 = 0, imm = 5, use_imm = 1, illegal = 0, pc = 0x1000.
- Enqueue 0x402081B3 (sub x3,x1,x2), 0x123452B7 (lui x5,0x12345), 0x00008067 (jalr x0,0(x1)).
  - Required: op = SUB with use_imm = 0; then LUI with imm = 0x12345000; then JALR with jalr = 1 and branch = 1.
- Enqueue 0xFE000EE3 (beq x0,x0,-4) and 0x41F0D093 (srai x1,x1,31).
  - Required: imm = 0xFFFFFFFC for the beq; op = SRA with imm = 31 for the srai.
- Enqueue 0x00000000 and 0x0000307F.
  - Required: illegal = 1 for both; op = ADD; branch, ls and jalr all 0.
- DEPTH = 4, out_ready = 0, push 5 instructions.
  - Required: count = 4 and in_ready = 0 with the 5th held.
  - Then assert out_ready together with in_valid: count stays 4, the 5th enters after the first pop.
  - Full order is preserved across pointer wrap over 10 entries.
- With 3 entries queued, assert flush together with in_valid and out_ready.
  - Required: next cycle count = 0, out_valid = 0, nothing from that cycle was enqueued.
  - Pull rst_n low mid-stream: count = 0 immediately, without waiting for a clock edge.
